// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetch requests, returns words after LATENCY
// cycles through a credit-limited first-word-fall-through response FIFO.
module imem_responder #(
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 2,
  parameter int          RSP_DEPTH = LATENCY + 1,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        o_req_ready,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_instr,
  output logic [31:0] o_rsp_addr,
  output logic        o_rsp_err,
  input  logic        i_rsp_ready,
  input  logic        i_flush,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  typedef struct packed {
    logic        err;
    logic [31:0] addr;
    logic [31:0] instr;
  } rsp_ent_t;

  // Handshakes: a request transfers on an edge with i_req_valid & o_req_ready; a
  // response transfers on an edge with o_rsp_valid & i_rsp_ready, and o_rsp_* stay
  // stable while valid is high and ready is low. Neither ready depends on the other side.

  logic [31:0]      mem_q [MEM_WORDS];
  logic [29:0]      rd_word;
  logic [29:0]      wr_word;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_in_range;
  logic             wr_in_range;
  logic             misaligned;
  logic             wr_bypass;
  logic             unused_wr_lsb;
  rsp_ent_t         new_ent;

  assign rd_word       = i_req_addr[31:2];
  assign wr_word       = i_wr_addr[31:2];
  assign rd_idx        = rd_word[IDX_W-1:0];
  assign wr_idx        = wr_word[IDX_W-1:0];
  assign rd_in_range   = (rd_word < 30'(MEM_WORDS));
  assign wr_in_range   = (wr_word < 30'(MEM_WORDS));
  assign misaligned    = |i_req_addr[1:0];
  assign wr_bypass     = i_wr_en & wr_in_range & (wr_idx == rd_idx);
  assign unused_wr_lsb = ^i_wr_addr[1:0];

  // Loader writes beyond the store are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (i_wr_en && wr_in_range) begin
      mem_q[wr_idx] <= i_wr_data;
    end
  end

  // The word is looked up at acceptance; a same-edge write wins so the fetch sees new data.
  always_comb begin
    new_ent.err   = misaligned | ~rd_in_range;
    new_ent.addr  = i_req_addr;
    new_ent.instr = NOP_INSTR;
    if (!new_ent.err) begin
      new_ent.instr = wr_bypass ? i_wr_data : mem_q[rd_idx];
    end
  end

  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  rsp_ent_t         fifo_q [RSP_DEPTH];
  rsp_ent_t         head;
  logic             acc;
  logic             cons;
  logic             rsp_valid;
  logic             push_vld;
  rsp_ent_t         push_ent;

  assign o_req_ready = rst_n & ~i_flush & (outst_q < CNT_W'(RSP_DEPTH));
  assign acc         = i_req_valid & o_req_ready;
  assign rsp_valid   = (fifo_cnt_q != '0);
  assign cons        = rsp_valid & i_rsp_ready;

  // LATENCY-1 register stages ahead of the FIFO; the FIFO write adds the final cycle.
  if (LATENCY == 1) begin : g_direct
    assign push_vld = acc;
    assign push_ent = new_ent;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld_q;
    rsp_ent_t           ent_q [LATENCY-1];

    always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= acc;
        for (int i = 1; i < LATENCY - 1; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      ent_q[0] <= new_ent;
      for (int i = 1; i < LATENCY - 1; i++) begin
        ent_q[i] <= ent_q[i-1];
      end
    end

    assign push_vld = vld_q[LATENCY-2];
    assign push_ent = ent_q[LATENCY-2];
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The outstanding credit bounds pipe + FIFO occupancy, so push never meets a full FIFO.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push_vld) - CNT_W'(cons);
    outst_d    = outst_q + CNT_W'(acc) - CNT_W'(cons);
    if (push_vld) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (cons) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (i_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
      outst_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      outst_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      outst_q    <= outst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) begin
      fifo_q[wr_ptr_q] <= push_ent;
    end
  end

  // Outputs read as zero whenever nothing is presented, including right after reset.
  assign head        = fifo_q[rd_ptr_q];
  assign o_rsp_valid = rsp_valid;
  assign o_rsp_instr = rsp_valid ? head.instr : '0;
  assign o_rsp_addr  = rsp_valid ? head.addr  : '0;
  assign o_rsp_err   = rsp_valid & head.err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a LATENCY=2 instance and a LATENCY=1 instance
// driven from one vector table, plus hand-written reset/scoreboard sequences.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] A0  = 32'hA0A0_0000;
  localparam logic [31:0] A1  = 32'hA0A0_0001;
  localparam logic [31:0] A2  = 32'hA0A0_0002;
  localparam logic [31:0] A3  = 32'hA0A0_0003;
  localparam logic [31:0] WL  = 32'h5A5A_5A5A;  // last word of the store
  localparam logic [31:0] DB  = 32'hDEAD_BEEF;
  localparam logic [31:0] CF  = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_addr, wr_data;

  logic        r0_req_valid, r0_rsp_ready, r0_flush, r0_req_ready, r0_rsp_valid, r0_rsp_err;
  logic [31:0] r0_req_addr, r0_rsp_instr, r0_rsp_addr;
  logic        r1_req_valid, r1_rsp_ready, r1_flush, r1_req_ready, r1_rsp_valid, r1_rsp_err;
  logic [31:0] r1_req_addr, r1_rsp_instr, r1_rsp_addr;

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(r0_req_valid), .i_req_addr(r0_req_addr), .o_req_ready(r0_req_ready),
    .o_rsp_valid(r0_rsp_valid), .o_rsp_instr(r0_rsp_instr), .o_rsp_addr(r0_rsp_addr),
    .o_rsp_err(r0_rsp_err), .i_rsp_ready(r0_rsp_ready), .i_flush(r0_flush),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data)
  );

  imem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(r1_req_valid), .i_req_addr(r1_req_addr), .o_req_ready(r1_req_ready),
    .o_rsp_valid(r1_rsp_valid), .o_rsp_instr(r1_rsp_instr), .o_rsp_addr(r1_rsp_addr),
    .o_rsp_err(r1_rsp_err), .i_rsp_ready(r1_rsp_ready), .i_flush(r1_flush),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data)
  );

  typedef struct {
    int          tid;
    int          dut;
    logic        rv;
    logic [31:0] ra;
    logic        rr;
    logic        fl;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        e_rdy;
    logic        e_val;
    logic [31:0] e_instr;
    logic [31:0] e_addr;
    logic        e_err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input int tid, input int dut, input logic rv, input logic [31:0] ra,
                              input logic rr, input logic fl, input logic we, input logic [31:0] wa,
                              input logic [31:0] wd, input logic e_rdy, input logic e_val,
                              input logic [31:0] e_instr, input logic [31:0] e_addr, input logic e_err);
    vec_t t;
    t.tid = tid; t.dut = dut; t.rv = rv; t.ra = ra; t.rr = rr; t.fl = fl;
    t.we = we; t.wa = wa; t.wd = wd; t.e_rdy = e_rdy; t.e_val = e_val;
    t.e_instr = e_instr; t.e_addr = e_addr; t.e_err = e_err;
    vecs.push_back(t);
  endfunction

  task automatic drive_idle();
    r0_req_valid = 1'b0; r0_req_addr = '0; r0_rsp_ready = 1'b1; r0_flush = 1'b0;
    r1_req_valid = 1'b0; r1_req_addr = '0; r1_rsp_ready = 1'b1; r1_flush = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic fill_table();
    // T1: back-to-back reads, first response two cycles after the first accept
    add(1,0, 1,32'h0,1,0, 0,0,0, 1,0,0,0,0);
    add(1,0, 1,32'h4,1,0, 0,0,0, 1,0,0,0,0);
    add(1,0, 1,32'h8,1,0, 0,0,0, 1,1,A0,32'h0,0);
    add(1,0, 1,32'hC,1,0, 0,0,0, 1,1,A1,32'h4,0);
    add(1,0, 0,32'h0,1,0, 0,0,0, 1,1,A2,32'h8,0);
    add(1,0, 0,32'h0,1,0, 0,0,0, 1,1,A3,32'hC,0);
    add(1,0, 0,32'h0,1,0, 0,0,0, 1,0,0,0,0);
    // T2: stall, three accepts then ready drops; release drains in order
    add(2,0, 1,32'h0,0,0, 0,0,0, 1,0,0,0,0);
    add(2,0, 1,32'h4,0,0, 0,0,0, 1,0,0,0,0);
    add(2,0, 1,32'h8,0,0, 0,0,0, 1,1,A0,32'h0,0);
    add(2,0, 1,32'hC,0,0, 0,0,0, 0,1,A0,32'h0,0);
    add(2,0, 1,32'hC,0,0, 0,0,0, 0,1,A0,32'h0,0);
    add(2,0, 0,32'h0,1,0, 0,0,0, 0,1,A0,32'h0,0);
    add(2,0, 0,32'h0,1,0, 0,0,0, 1,1,A1,32'h4,0);
    add(2,0, 0,32'h0,1,0, 0,0,0, 1,1,A2,32'h8,0);
    add(2,0, 0,32'h0,1,0, 0,0,0, 1,0,0,0,0);
    // T3: flush with a full credit; nothing stale returns, next read is clean
    add(3,0, 1,32'h4,0,0, 0,0,0, 1,0,0,0,0);
    add(3,0, 1,32'h8,0,0, 0,0,0, 1,0,0,0,0);
    add(3,0, 1,32'hC,0,0, 0,0,0, 1,1,A1,32'h4,0);
    add(3,0, 1,32'h0,0,1, 0,0,0, 0,1,A1,32'h4,0);
    add(3,0, 1,32'h8,1,0, 0,0,0, 1,0,0,0,0);
    add(3,0, 0,32'h0,1,0, 0,0,0, 1,0,0,0,0);
    add(3,0, 0,32'h0,1,0, 0,0,0, 1,1,A2,32'h8,0);
    add(3,0, 0,32'h0,1,0, 0,0,0, 1,0,0,0,0);
    // T4: misaligned and out-of-range requests interleaved with good ones
    add(4,0, 1,32'h0,1,0, 0,0,0, 1,0,0,0,0);
    add(4,0, 1,32'h2,1,0, 0,0,0, 1,0,0,0,0);
    add(4,0, 1,32'h1000,1,0, 0,0,0, 1,1,A0,32'h0,0);
    add(4,0, 1,32'hFFC,1,0, 0,0,0, 1,1,NOP,32'h2,1);
    add(4,0, 1,32'h8000_0000,1,0, 0,0,0, 1,1,NOP,32'h1000,1);
    add(4,0, 1,32'h4,1,0, 0,0,0, 1,1,WL,32'hFFC,0);
    add(4,0, 0,32'h0,1,0, 0,0,0, 1,1,NOP,32'h8000_0000,1);
    add(4,0, 0,32'h0,1,0, 0,0,0, 1,1,A1,32'h4,0);
    add(4,0, 0,32'h0,1,0, 0,0,0, 1,0,0,0,0);
    // T6: same-edge write and read of one word returns the new data
    add(6,0, 1,32'h4,1,0, 1,32'h4,DB, 1,0,0,0,0);
    add(6,0, 0,32'h0,1,0, 0,0,0, 1,0,0,0,0);
    add(6,0, 0,32'h0,1,0, 0,0,0, 1,1,DB,32'h4,0);
    add(6,0, 0,32'h0,1,0, 0,0,0, 1,0,0,0,0);
    // T7: LATENCY=1 instance (depth 2): next-cycle response, credit of two, bypass
    add(7,1, 1,32'h8,0,0, 0,0,0, 1,0,0,0,0);
    add(7,1, 1,32'hC,0,0, 0,0,0, 1,1,A2,32'h8,0);
    add(7,1, 1,32'h0,0,0, 0,0,0, 0,1,A2,32'h8,0);
    add(7,1, 0,32'h0,1,0, 0,0,0, 0,1,A2,32'h8,0);
    add(7,1, 0,32'h0,1,0, 0,0,0, 1,1,A3,32'hC,0);
    add(7,1, 1,32'h0,1,0, 1,32'h0,CF, 1,0,0,0,0);
    add(7,1, 0,32'h0,1,0, 0,0,0, 1,1,CF,32'h0,0);
    add(7,1, 0,32'h0,1,0, 0,0,0, 1,0,0,0,0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    rst_n = 1'b0;
    drive_idle();

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst r0 ready", 32'(r0_req_ready), 32'h0);
    chk("rst r0 valid", 32'(r0_rsp_valid), 32'h0);
    chk("rst r0 instr", r0_rsp_instr, 32'h0);
    chk("rst r0 addr", r0_rsp_addr, 32'h0);
    chk("rst r0 err", 32'(r0_rsp_err), 32'h0);
    chk("rst r1 ready", 32'(r1_req_ready), 32'h0);
    chk("rst r1 valid", 32'(r1_rsp_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst r0 ready", 32'(r0_req_ready), 32'h1);

    load_word(32'h0, A0);
    load_word(32'h4, A1);
    load_word(32'h8, A2);
    load_word(32'hC, A3);
    load_word(32'hFFC, WL);

    // T5: reset with two outstanding, then memory still holds A0..A3
    @(negedge clk);
    r0_rsp_ready = 1'b0; r0_req_valid = 1'b1; r0_req_addr = 32'h0;
    #1 chk("t5 acc0 ready", 32'(r0_req_ready), 32'h1);
    @(negedge clk);
    r0_req_addr = 32'h4;
    #1 chk("t5 acc1 ready", 32'(r0_req_ready), 32'h1);
    @(negedge clk);
    r0_req_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("t5 pre-rst instr", r0_rsp_instr, A0);
    chk("t5 in-rst ready", 32'(r0_req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; r0_rsp_ready = 1'b1;
    #1;
    chk("t5 after-rst valid", 32'(r0_rsp_valid), 32'h0);
    chk("t5 after-rst instr", r0_rsp_instr, 32'h0);
    chk("t5 after-rst addr", r0_rsp_addr, 32'h0);
    chk("t5 after-rst err", 32'(r0_rsp_err), 32'h0);
    chk("t5 after-rst ready", 32'(r0_req_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("t5 no stale", 32'(r0_rsp_valid), 32'h0);
    end
    exp_q.push_back(A0); exp_q.push_back(A1); exp_q.push_back(A2); exp_q.push_back(A3);
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'(i * 4));
    idx = 0;
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      r0_req_valid = (idx < 4);
      r0_req_addr  = 32'(idx * 4);
      #1;
      if (r0_req_valid && r0_req_ready) idx++;
      if (r0_rsp_valid) begin
        chk("t5 sb instr", r0_rsp_instr, exp_q.pop_front());
        chk("t5 sb addr", r0_rsp_addr, exp_addr_q.pop_front());
        chk("t5 sb err", 32'(r0_rsp_err), 32'h0);
      end
    end
    chk("t5 sb leftover", 32'(exp_q.size()), 32'h0);
    @(negedge clk);
    drive_idle();

    // Table-driven tests
    fill_table();
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t        v;
      logic        a_rdy, a_val, a_err;
      logic [31:0] a_instr, a_addr;
      string       nm;
      v = vecs[i];
      @(negedge clk);
      drive_idle();
      wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
      if (v.dut == 0) begin
        r0_req_valid = v.rv; r0_req_addr = v.ra; r0_rsp_ready = v.rr; r0_flush = v.fl;
      end else begin
        r1_req_valid = v.rv; r1_req_addr = v.ra; r1_rsp_ready = v.rr; r1_flush = v.fl;
      end
      #1;
      a_rdy   = (v.dut == 0) ? r0_req_ready : r1_req_ready;
      a_val   = (v.dut == 0) ? r0_rsp_valid : r1_rsp_valid;
      a_instr = (v.dut == 0) ? r0_rsp_instr : r1_rsp_instr;
      a_addr  = (v.dut == 0) ? r0_rsp_addr  : r1_rsp_addr;
      a_err   = (v.dut == 0) ? r0_rsp_err   : r1_rsp_err;
      nm = $sformatf("T%0d v%0d", v.tid, i);
      chk({nm, " ready"}, 32'(a_rdy), 32'(v.e_rdy));
      chk({nm, " valid"}, 32'(a_val), 32'(v.e_val));
      chk({nm, " instr"}, a_instr, v.e_instr);
      chk({nm, " addr"}, a_addr, v.e_addr);
      chk({nm, " err"}, 32'(a_err), 32'(v.e_err));
    end
    @(negedge clk);
    drive_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
